// File: rtl/matrix_multiplication_if.sv
// Operand/result bus and start/done handshake for the 3x3 matrix multiplier.
// Handshake: start is sampled on a rising edge in IDLE or DONE; done stays high with C_flat valid until the next accepted start.
interface matrix_multiplication_if #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8
);
  logic                        start;
  logic [N*N*DATA_WIDTH-1:0]   A_flat;
  logic [N*N*DATA_WIDTH-1:0]   B_flat;
  logic [N*N*DATA_WIDTH-1:0]   C_flat;
  logic                        done;

  modport master (output start, output A_flat, output B_flat, input C_flat, input done);
  modport slave  (input start, input A_flat, input B_flat, output C_flat, output done);
endinterface

// File: rtl/matrix_multiplication.sv
// Sequential NxN unsigned matrix multiplier, one multiply-accumulate per clock.
// Operands are latched on start; C is built element by element and valid while done=1.
module matrix_multiplication #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input  logic                      clk,
  input  logic                      reset,
  matrix_multiplication_if.slave    bus,
  output logic [1:0]                fsm_state
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST    = CW'(N - 1);
  localparam logic [CW-1:0] ROW_END = CW'(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]   a_op  [N][N];
  logic [DATA_WIDTH-1:0]   b_op  [N][N];
  logic [DATA_WIDTH-1:0]   c_reg [N][N];
  logic [CW-1:0]           i, j, k;
  logic [CW-1:0]           i_sel;
  logic [ACC_WIDTH-1:0]    acc;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    sum;
  logic                    load;

  assign load      = bus.start && (state == IDLE || state == DONE);
  assign i_sel     = (i == ROW_END) ? '0 : i;
  assign prod      = a_op[i_sel][k] * b_op[k][j];
  assign sum       = acc + ACC_WIDTH'(prod);
  assign bus.done  = (state == DONE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Row index reaching N marks a one-cycle drain after C[N-1][N-1] is written.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = COMPUTE;
      COMPUTE: if (i == ROW_END) state_next = DONE;
      DONE:    if (bus.start) state_next = COMPUTE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      acc <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_op[r][c]  <= '0;
          b_op[r][c]  <= '0;
          c_reg[r][c] <= '0;
        end
      end
    end else if (load) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      acc <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_op[r][c]  <= bus.A_flat[(N*N-1-(N*r+c))*DATA_WIDTH +: DATA_WIDTH];
          b_op[r][c]  <= bus.B_flat[(N*N-1-(N*r+c))*DATA_WIDTH +: DATA_WIDTH];
          c_reg[r][c] <= '0;
        end
      end
    end else if (state == COMPUTE && i != ROW_END) begin
      if (k != LAST) begin
        acc <= sum;
        k   <= k + CW'(1);
      end else begin
        c_reg[i_sel][j] <= sum[DATA_WIDTH-1:0];
        acc <= '0;
        k   <= '0;
        if (j == LAST) begin
          j <= '0;
          i <= i + CW'(1);
        end else begin
          j <= j + CW'(1);
        end
      end
    end
  end

  always_comb begin
    bus.C_flat = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        bus.C_flat[(N*N-1-(N*r+c))*DATA_WIDTH +: DATA_WIDTH] = c_reg[r][c];
      end
    end
  end
endmodule

// File: tb/tb_matrix_multiplication.sv
// Self-checking bench for matrix_multiplication against a loop-based matrix product model.
module tb_matrix_multiplication;
  logic       clk;
  logic       reset;
  logic [1:0] fsm_state;
  int         errors;
  int         checks;

  matrix_multiplication_if #(.N(3), .DATA_WIDTH(8)) mif ();

  matrix_multiplication dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (mif),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [71:0] A_NOM = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [71:0] B_NOM = 72'h01_02_03_04_05_06_07_08_09;
  localparam logic [71:0] C_NOM = 72'h5A_72_8A_36_45_54_12_18_1E;
  localparam logic [71:0] ID3   = 72'h01_00_00_00_01_00_00_00_01;

  // reference model: plain row-by-column sums, reduced mod 256
  function automatic logic [71:0] ref_mul(input logic [71:0] a, input logic [71:0] b);
    logic [71:0] res;
    int unsigned sum;
    res = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        sum = 0;
        for (int x = 0; x < 3; x++)
          sum += int'(a[71-8*(3*r+x) -: 8]) * int'(b[71-8*(3*x+c) -: 8]);
        res[71-8*(3*r+c) -: 8] = 8'(sum % 256);
      end
    end
    return res;
  endfunction

  function automatic logic [71:0] rand72();
    return {$urandom(), $urandom(), 8'($urandom())};
  endfunction

  // drivers
  task automatic pulse_start();
    @(negedge clk);
    mif.start = 1'b1;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!mif.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mif.start  = 1'($urandom_range(0, 1));
      mif.A_flat = rand72();
      mif.B_flat = rand72();
      @(posedge clk);
      #1;
      checks++;
      if (mif.C_flat !== 72'h0 || mif.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: C=%h done=%b, required C=0 done=0", mif.C_flat, mif.done);
      end
    end
    @(negedge clk);
    mif.start = 1'b0;
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      checks++;
      if (mif.done !== 1'b0 || mif.C_flat !== 72'h0) begin
        errors++;
        $display("FAIL reset_release_idle: C=%h done=%b, required C=0 done=0", mif.C_flat, mif.done);
      end
    end
  endtask

  task automatic test_nominal();
    int n;
    mif.A_flat = A_NOM;
    mif.B_flat = B_NOM;
    pulse_start();
    checks++;
    if (mif.done !== 1'b0) begin
      errors++;
      $display("FAIL nominal_busy: done=%b, required 0", mif.done);
    end
    wait_done(0, n);
    checks++;
    if (n !== 28) begin
      errors++;
      $display("FAIL nominal_latency: %0d edges, required 28", n);
    end
    checks++;
    if (mif.C_flat !== C_NOM) begin
      errors++;
      $display("FAIL nominal_result: C=%h, required %h", mif.C_flat, C_NOM);
    end
    mif.A_flat = rand72();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (mif.done !== 1'b1 || mif.C_flat !== C_NOM) begin
      errors++;
      $display("FAIL nominal_hold: C=%h done=%b, required C=%h done=1", mif.C_flat, mif.done, C_NOM);
    end
  endtask

  task automatic test_overflow();
    int n;
    logic [71:0] ones;
    ones = '1;
    mif.A_flat = ones;
    mif.B_flat = ones;
    pulse_start();
    wait_done(0, n);
    checks++;
    if (mif.done !== 1'b1 || mif.C_flat !== {9{8'h03}}) begin
      errors++;
      $display("FAIL overflow_255: C=%h done=%b, required C=%h done=1", mif.C_flat, mif.done, {9{8'h03}});
    end
    mif.A_flat = ID3;
    mif.B_flat = B_NOM;
    pulse_start();
    wait_done(0, n);
    checks++;
    if (mif.done !== 1'b1 || mif.C_flat !== B_NOM) begin
      errors++;
      $display("FAIL identity: C=%h done=%b, required C=%h done=1", mif.C_flat, mif.done, B_NOM);
    end
  endtask

  task automatic test_random();
    int n;
    logic [71:0] a, b, exp_q[$];
    for (int t = 0; t < 6; t++) begin
      a = rand72();
      b = rand72();
      exp_q.push_back(ref_mul(a, b));
      mif.A_flat = a;
      mif.B_flat = b;
      pulse_start();
      wait_done(0, n);
      checks++;
      if (n !== 28 || mif.C_flat !== exp_q[0]) begin
        errors++;
        $display("FAIL random_%0d: C=%h after %0d edges, required %h after 28", t, mif.C_flat, n, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_isolation();
    int n;
    mif.A_flat = A_NOM;
    mif.B_flat = B_NOM;
    pulse_start();
    mif.A_flat = '0;
    mif.B_flat = '0;
    n = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    mif.start = 1'b1;
    @(posedge clk);
    #1;
    n++;
    mif.start = 1'b0;
    wait_done(n, n);
    checks++;
    if (n !== 28 || mif.C_flat !== C_NOM) begin
      errors++;
      $display("FAIL isolation: C=%h after %0d edges, required %h after 28", mif.C_flat, n, C_NOM);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    logic [71:0] a, b;
    mif.A_flat = A_NOM;
    mif.B_flat = B_NOM;
    pulse_start();
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (mif.C_flat !== 72'h0 || mif.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: C=%h done=%b, required C=0 done=0", mif.C_flat, mif.done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (mif.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_completion: done=%b, required 0", mif.done);
    end
    a = rand72();
    b = rand72();
    mif.A_flat = a;
    mif.B_flat = b;
    pulse_start();
    wait_done(0, n);
    checks++;
    if (n !== 28 || mif.C_flat !== ref_mul(a, b)) begin
      errors++;
      $display("FAIL mid_reset_restart: C=%h after %0d edges, required %h after 28", mif.C_flat, n, ref_mul(a, b));
    end
  endtask

  task automatic test_back_to_back();
    int n;
    checks++;
    if (mif.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_precondition: done=%b, required 1", mif.done);
    end
    mif.A_flat = ID3;
    mif.B_flat = B_NOM;
    pulse_start();
    checks++;
    if (mif.done !== 1'b0 || mif.C_flat !== 72'h0) begin
      errors++;
      $display("FAIL b2b_done_falls: C=%h done=%b, required C=0 done=0", mif.C_flat, mif.done);
    end
    wait_done(0, n);
    checks++;
    if (n !== 28 || mif.C_flat !== B_NOM) begin
      errors++;
      $display("FAIL b2b_result: C=%h after %0d edges, required %h after 28", mif.C_flat, n, B_NOM);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b0;
    mif.start  = 1'b0;
    mif.A_flat = '0;
    mif.B_flat = '0;
    test_reset();
    test_nominal();
    test_overflow();
    test_random();
    test_isolation();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
